// File: rtl/demux_1to3_stage_if.sv
// Stream bundle for the 1-to-3 demultiplexer: one producer-side stream
// plus three consumer-side channels with their error/drop status.
interface demux_1to3_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
);
  // producer side
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_valid;
  logic [1:0]            i_sel;
  logic                  o_ready;

  // consumer channels
  logic [DATA_WIDTH-1:0] o_data1;
  logic [DATA_WIDTH-1:0] o_data2;
  logic [DATA_WIDTH-1:0] o_data3;
  logic                  o_valid1;
  logic                  o_valid2;
  logic                  o_valid3;
  logic                  i_ready1;
  logic                  i_ready2;
  logic                  i_ready3;

  // drop status
  logic                  o_err;
  logic [CNT_WIDTH-1:0]  o_drop_cnt;

  // driver of the inputs (producer plus consumers)
  modport master (
    output i_data, i_valid, i_sel, i_ready1, i_ready2, i_ready3,
    input  o_ready, o_data1, o_data2, o_data3,
    input  o_valid1, o_valid2, o_valid3, o_err, o_drop_cnt
  );

  // the demultiplexer itself
  modport slave (
    input  i_data, i_valid, i_sel, i_ready1, i_ready2, i_ready3,
    output o_ready, o_data1, o_data2, o_data3,
    output o_valid1, o_valid2, o_valid3, o_err, o_drop_cnt
  );
endinterface

// File: rtl/demux_1to3_stage.sv
// Registered 1-to-3 stream demultiplexer. Each channel owns a single-entry
// output register, so only traffic aimed at a stalled consumer is blocked.
// Select 11 is accepted and discarded, raising o_err and bumping a
// saturating drop counter.
module demux_1to3_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input logic               i_clk,
  input logic               i_reset,
  demux_1to3_stage_if.slave bus
);

  localparam logic [1:0] SEL_DROP = 2'b11;

  logic [DATA_WIDTH-1:0] data_reg [3];
  logic [2:0]            valid_reg;
  logic [2:0]            ready_in;
  logic                  err_reg;
  logic [CNT_WIDTH-1:0]  drop_cnt_reg;
  logic                  ready_next;
  logic                  accept;
  logic                  drop;

  assign ready_in = {bus.i_ready3, bus.i_ready2, bus.i_ready1};

  // Ready looks only at the selected slot; select 11 always sinks.
  always_comb begin
    ready_next = 1'b1;
    case (bus.i_sel)
      2'b00:   ready_next = ~valid_reg[0] | ready_in[0];
      2'b01:   ready_next = ~valid_reg[1] | ready_in[1];
      2'b10:   ready_next = ~valid_reg[2] | ready_in[2];
      default: ready_next = 1'b1;
    endcase
  end

  assign bus.o_ready = ready_next;
  assign accept      = bus.i_valid & ready_next;
  assign drop        = accept & (bus.i_sel == SEL_DROP);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_slot
      // A load wins over a drain, so a draining slot refills with no bubble.
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          data_reg[gi]  <= '0;
          valid_reg[gi] <= 1'b0;
        end else if (accept && (bus.i_sel == 2'(gi))) begin
          data_reg[gi]  <= bus.i_data;
          valid_reg[gi] <= 1'b1;
        end else if (valid_reg[gi] && ready_in[gi]) begin
          valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Error pulse and saturating count of invalid-select drops.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      err_reg      <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      err_reg <= drop;
      if (drop && (drop_cnt_reg != {CNT_WIDTH{1'b1}})) begin
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.o_data1    = data_reg[0];
  assign bus.o_data2    = data_reg[1];
  assign bus.o_data3    = data_reg[2];
  assign bus.o_valid1   = valid_reg[0];
  assign bus.o_valid2   = valid_reg[1];
  assign bus.o_valid3   = valid_reg[2];
  assign bus.o_err      = err_reg;
  assign bus.o_drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_demux_1to3_stage.sv
// Self-checking bench for demux_1to3_stage: directed scenarios plus a
// random traffic phase, with per-channel scoreboard queues.
module tb_demux_1to3_stage;

  localparam int DW = 32;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  demux_1to3_stage_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  demux_1to3_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [DW-1:0] sb_q0 [$];
  logic [DW-1:0] sb_q1 [$];
  logic [DW-1:0] sb_q2 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // compare a word leaving channel ch against the oldest one sent there
  task automatic pop_chk(input int ch, input logic [DW-1:0] obs);
    logic [DW-1:0] exp;
    int n;
    case (ch)
      0:       n = sb_q0.size();
      1:       n = sb_q1.size();
      default: n = sb_q2.size();
    endcase
    if (n == 0) begin
      chk($sformatf("unexpected_word_ch%0d", ch + 1), obs, 32'hxxxx_xxxx ^ obs);
      return;
    end
    case (ch)
      0:       exp = sb_q0.pop_front();
      1:       exp = sb_q1.pop_front();
      default: exp = sb_q2.pop_front();
    endcase
    chk($sformatf("data_ch%0d", ch + 1), obs, exp);
    $display("ch%0d out %h", ch + 1, obs);
  endtask

  // Scoreboard: push accepted words, pop on each consumer handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb_q0.delete();
      sb_q1.delete();
      sb_q2.delete();
    end else begin
      if (bus.o_valid1 && bus.i_ready1) pop_chk(0, bus.o_data1);
      if (bus.o_valid2 && bus.i_ready2) pop_chk(1, bus.o_data2);
      if (bus.o_valid3 && bus.i_ready3) pop_chk(2, bus.o_data3);
      if (bus.i_valid && bus.o_ready) begin
        case (bus.i_sel)
          2'b00:   sb_q0.push_back(bus.i_data);
          2'b01:   sb_q1.push_back(bus.i_data);
          2'b10:   sb_q2.push_back(bus.i_data);
          default: ;
        endcase
      end
    end
  end

  task automatic idle_in();
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_sel   = 2'b00;
  endtask

  task automatic send(input logic [1:0] sel, input logic [DW-1:0] d);
    bus.i_sel   = sel;
    bus.i_data  = d;
    bus.i_valid = 1'b1;
    #1;
  endtask

  initial begin
    idle_in();
    bus.i_ready1 = 1'b1;
    bus.i_ready2 = 1'b1;
    bus.i_ready3 = 1'b1;

    // reset then idle
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", {29'd0, bus.o_valid3, bus.o_valid2, bus.o_valid1}, 32'd0);
    chk("rst_data1", bus.o_data1, 32'd0);
    chk("rst_data2", bus.o_data2, 32'd0);
    chk("rst_data3", bus.o_data3, 32'd0);
    chk("rst_err", {31'd0, bus.o_err}, 32'd0);
    chk("rst_cnt", {30'd0, bus.o_drop_cnt}, 32'd0);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      bus.i_sel = 2'(s);
      #1;
      chk($sformatf("idle_ready_sel%0d", s), {31'd0, bus.o_ready}, 32'd1);
    end

    // basic route to ch2
    send(2'b01, 32'hA5A5_0001);
    tick();
    idle_in();
    chk("basic_valid2", {31'd0, bus.o_valid2}, 32'd1);
    chk("basic_data2", bus.o_data2, 32'hA5A5_0001);
    chk("basic_others", {30'd0, bus.o_valid3, bus.o_valid1}, 32'd0);
    tick();
    chk("basic_drained", {31'd0, bus.o_valid2}, 32'd0);

    // backpressure on ch1 while ch3 still accepts
    bus.i_ready1 = 1'b0;
    bus.i_ready3 = 1'b0;
    send(2'b00, 32'h11);
    tick();
    idle_in();
    bus.i_sel = 2'b00;
    #1;
    chk("bp_ready_sel0", {31'd0, bus.o_ready}, 32'd0);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) send(2'b10, 32'h33);
      else if (c == 3) send(2'b00, 32'hDEAD);
      tick();
      if (c == 1) begin
        chk("bp_valid3", {31'd0, bus.o_valid3}, 32'd1);
        chk("bp_data3", bus.o_data3, 32'h33);
      end
      idle_in();
      chk("bp_hold_valid1", {31'd0, bus.o_valid1}, 32'd1);
      chk("bp_hold_data1", bus.o_data1, 32'h11);
    end
    bus.i_ready3 = 1'b1;
    tick();
    chk("bp_ch3_drained", {31'd0, bus.o_valid3}, 32'd0);

    // simultaneous drain + load, then 4-word stream
    bus.i_ready1 = 1'b1;
    send(2'b00, 32'h22);
    chk("dl_ready", {31'd0, bus.o_ready}, 32'd1);
    tick();
    chk("dl_valid1", {31'd0, bus.o_valid1}, 32'd1);
    chk("dl_data1", bus.o_data1, 32'h22);
    for (int w = 0; w < 4; w++) begin
      send(2'b00, 32'h100 + 32'(w));
      tick();
      chk($sformatf("stream_valid_%0d", w), {31'd0, bus.o_valid1}, 32'd1);
      chk($sformatf("stream_data_%0d", w), bus.o_data1, 32'h100 + 32'(w));
    end
    idle_in();
    tick();
    chk("stream_end", {31'd0, bus.o_valid1}, 32'd0);

    // invalid select: drops, err pulses, saturating counter
    for (int k = 0; k < 5; k++) begin
      send(2'b11, 32'hBAD0 + 32'(k));
      chk($sformatf("drop_ready_%0d", k), {31'd0, bus.o_ready}, 32'd1);
      tick();
      chk($sformatf("drop_err_%0d", k), {31'd0, bus.o_err}, 32'd1);
      chk($sformatf("drop_cnt_%0d", k), {30'd0, bus.o_drop_cnt}, (k < 3) ? 32'(k + 1) : 32'd3);
      chk($sformatf("drop_novalid_%0d", k), {29'd0, bus.o_valid3, bus.o_valid2, bus.o_valid1}, 32'd0);
    end
    idle_in();
    tick();
    chk("drop_err_clear", {31'd0, bus.o_err}, 32'd0);
    chk("drop_cnt_sat", {30'd0, bus.o_drop_cnt}, 32'd3);

    // reset mid-operation with all slots full
    bus.i_ready1 = 1'b0;
    bus.i_ready2 = 1'b0;
    bus.i_ready3 = 1'b0;
    send(2'b00, 32'hAAA1); tick();
    send(2'b01, 32'hAAA2); tick();
    send(2'b10, 32'hAAA3); tick();
    idle_in();
    chk("full_valid", {29'd0, bus.o_valid3, bus.o_valid2, bus.o_valid1}, 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", {29'd0, bus.o_valid3, bus.o_valid2, bus.o_valid1}, 32'd0);
    chk("midrst_cnt", {30'd0, bus.o_drop_cnt}, 32'd0);
    bus.i_ready1 = 1'b1;
    bus.i_ready2 = 1'b1;
    bus.i_ready3 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_rst_quiet", {29'd0, bus.o_valid3, bus.o_valid2, bus.o_valid1}, 32'd0);
    end

    // random traffic with random consumer stalls
    for (int c = 0; c < 300; c++) begin
      bus.i_ready1 = 1'($urandom_range(0, 1));
      bus.i_ready2 = 1'($urandom_range(0, 1));
      bus.i_ready3 = 1'($urandom_range(0, 1));
      bus.i_sel    = 2'($urandom_range(0, 3));
      bus.i_data   = $urandom;
      bus.i_valid  = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle_in();
    bus.i_ready1 = 1'b1;
    bus.i_ready2 = 1'b1;
    bus.i_ready3 = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("final_q_empty", 32'(sb_q0.size() + sb_q1.size() + sb_q2.size()), 32'd0);
    chk("final_idle", {29'd0, bus.o_valid3, bus.o_valid2, bus.o_valid1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/demux_1to3_stage.md
Name: demux_1to3_stage

Overview:
- Registered 1-to-3 stream demultiplexer: the distribute-side counterpart of the 3-to-1 select mux.
- Routes one producer stream to one of three consumer channels by a 2-bit select, using valid/ready handshakes.
- Each channel has a single-entry output register, so a stalled consumer only blocks traffic aimed at that consumer.
- Used to steer pipeline results (ALU / load-store / branch) to separate downstream units. Invalid select values are dropped, flagged and counted.

Parameters:
- DATA_WIDTH, 32, width of the data word.
- CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_reset  input  1  synchronous, active-high reset
- i_data  input  DATA_WIDTH  input data word
- i_valid  input  1  input word valid
- i_sel  input  2  destination: 00 -> ch1, 01 -> ch2, 10 -> ch3, 11 -> invalid
- o_ready  output  1  input can be accepted this cycle (combinational)
- o_data1, o_data2, o_data3  output  DATA_WIDTH each  channel data (registered)
- o_valid1, o_valid2, o_valid3  output  1 each  channel data valid (registered)
- i_ready1, i_ready2, i_ready3  input  1 each  consumer ready per channel
- o_err  output  1  one-cycle pulse, invalid-select word was dropped (registered)
- o_drop_cnt  output  CNT_WIDTH  count of dropped words, saturating

Behaviour:
- Reset (synchronous, i_reset=1 at the edge):
  - o_valid1..3=0, o_data1..3=0, o_err=0, o_drop_cnt=0.
  - Any word held in a slot is discarded.
  - o_ready is still driven combinationally during reset but no state changes.
- Ready, for selected channel k:
  - o_ready = ~o_validk | i_readyk.
  - For i_sel=11, o_ready=1.
  - Depends only on i_sel and the selected channel. Other channels' state has no effect.
- Accept: occurs when i_valid & o_ready, sampled at the rising edge.
- Slot k update, by priority:
  - Accept to k: o_datak<=i_data and o_validk<=1, even if the old word is draining this cycle. The old word is consumed and the new one replaces it with no bubble.
  - Else, if o_validk & i_readyk: o_validk<=0. o_datak holds its last value.
  - Else: hold.
- Latency and throughput:
  - 1 cycle from accept to o_validk=1.
  - Sustained 1 word/cycle per channel when the consumer ready is held high.
- Stability: while o_validk=1 and i_readyk=0, o_datak and o_validk stay constant.
- Invalid select (i_sel=11 with i_valid=1):
  - The word is accepted and discarded.
  - Next cycle o_err=1, otherwise o_err=0.
  - o_drop_cnt increments by 1 and saturates at 2^CNT_WIDTH-1 with no wrap.
- Independence:
  - Channels drain independently. A stalled ch1 does not block words to ch2 or ch3.
  - At most one slot loads per cycle. Any number of slots can drain in the same cycle.
- No state change when i_valid=0; i_data and i_sel are don't-care then.
- No data is lost or duplicated apart from invalid-select drops and reset.
- Implementation is fully synchronous. Only o_ready is combinational, with no path from i_valid to o_ready.

Test Plan:
- Reset then idle: hold i_reset 2 cycles -> o_valid1..3=0, o_data*=0, o_err=0, o_drop_cnt=0, o_ready=1 for every i_sel.
- Basic route: i_data=0xA5A5_0001, i_sel=01, i_valid=1, i_ready2=1 -> next cycle o_valid2=1 and o_data2=0xA5A5_0001; o_valid1 and o_valid3 stay 0.
- Backpressure: ch1 filled with 0x11, i_ready1=0 -> o_ready=0 for i_sel=00 and o_data1 stays 0x11 for 5 cycles. In the same window, i_sel=10 with 0x33 is accepted and o_valid3=1 the next cycle.
- Simultaneous drain + load: o_valid1=1 (0x11), i_ready1=1, new word 0x22 to ch1 -> next cycle o_valid1=1, o_data1=0x22. Streaming 4 words back-to-back gives 4 consecutive valid cycles with no bubbles.
- Invalid select: 3 words with i_sel=11 -> o_ready=1 each cycle, o_err pulses 3 cycles, o_drop_cnt=3, no channel goes valid. With CNT_WIDTH=2, 5 drops leave o_drop_cnt=3 (saturated).
- Reset mid-operation: all three slots valid with ready low, assert i_reset 1 cycle -> all o_valid*=0 and o_drop_cnt=0 next cycle; the pre-reset words never appear afterward.
